vram_write_arbiter: RTL and testbench

- Shares the single external VRAM pixel-write port between two requesters: the raster engine and the clear/fill engine.
- Stretches each write over a programmable number of cycles so the external SRAM write timing is met.
- Sequences front/back buffer swaps by toggling vram_offset only when no write is in flight.
- Sits between the gpu_wrapper requesters and the io_out pad mapping.

---
 rtl/vram_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 24 ++
 rtl/vram_write_arbiter.sv | 144 ++++++++++++++
 tb/tb_vram_write_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared widths, FSM state encoding and pixel colour type for the VRAM write path.
package vram_pkg;

   localparam int unsigned ADDR_W  = 18;
   localparam int unsigned COLOR_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      SWAP  = 2'd2
   } state_t;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, purely combinational.
// Ports:
//   valid_a  - requester A (raster) wants a grant
//   valid_b  - requester B (clear/fill) wants a grant
//   rr       - tie-break select when both are valid (0 = A, 1 = B)
//   grant_c  - one-hot grant, bit 0 = A, bit 1 = B; zero when nothing is valid
module rr_arbiter2 (
   input  logic       valid_a,
   input  logic       valid_b,
   input  logic       rr,
   output logic [1:0] grant_c
);

   // A wins when it is alone or when the pointer favours it.
   always_comb begin
      grant_c = 2'b00;
      if (valid_a && (!valid_b || !rr)) begin
         grant_c = 2'b01;
      end else if (valid_b) begin
         grant_c = 2'b10;
      end
   end

endmodule

// File: rtl/vram_write_arbiter.sv
// Shares the external VRAM pixel-write port between the raster and clear/fill
// engines, stretches each write strobe over WRITE_CYCLES cycles, and toggles
// the display buffer select only between writes.
// Ports:
//   wb_clk_i, wb_rst_ni                  - clock, async active-low reset
//   rast_valid/ready/addr/color          - raster engine write request
//   clr_valid/ready/addr/color           - clear/fill engine write request
//   swap_req / swap_done                 - buffer swap request pulse / completion pulse
//   busy                                 - write or swap in progress or pending
//   vram_write_pixel, vram_raster_address,
//   vram_raster_color, vram_offset       - registered VRAM pad signals
module vram_write_arbiter #(
   parameter int unsigned ADDR_W       = vram_pkg::ADDR_W,
   parameter int unsigned COLOR_W      = vram_pkg::COLOR_W,
   parameter int unsigned WRITE_CYCLES = 2
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_ni,
   input  logic               rast_valid,
   output logic               rast_ready,
   input  logic [ADDR_W-1:0]  rast_addr,
   input  logic [COLOR_W-1:0] rast_color,
   input  logic               clr_valid,
   output logic               clr_ready,
   input  logic [ADDR_W-1:0]  clr_addr,
   input  logic [COLOR_W-1:0] clr_color,
   input  logic               swap_req,
   output logic               swap_done,
   output logic               busy,
   output logic               vram_write_pixel,
   output logic [ADDR_W-1:0]  vram_raster_address,
   output logic [COLOR_W-1:0] vram_raster_color,
   output logic               vram_offset
);

   import vram_pkg::state_t;
   import vram_pkg::IDLE;
   import vram_pkg::WRITE;
   import vram_pkg::SWAP;

   localparam int unsigned CNT_W = 4;

   state_t             state, state_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic               swap_pending, swap_pending_d;
   logic               rr, rr_d;
   logic               write_pixel_d;
   logic [ADDR_W-1:0]  addr_d;
   logic [COLOR_W-1:0] color_d;
   logic               offset_d;
   logic               swap_done_d;
   logic               busy_d;
   logic [1:0]         grant_c;
   logic               accept_c;

   rr_arbiter2 u_rr_arbiter2 (
      .valid_a (rast_valid),
      .valid_b (clr_valid),
      .rr      (rr),
      .grant_c (grant_c)
   );

   // Grants only in IDLE with no swap waiting; held low while reset is asserted.
   assign accept_c   = wb_rst_ni && (state == IDLE) && !swap_pending;
   assign rast_ready = accept_c && grant_c[0];
   assign clr_ready  = accept_c && grant_c[1];

   // Next-state and next-output logic.
   always_comb begin
      state_d        = state;
      cnt_d          = cnt;
      swap_pending_d = swap_pending | swap_req;
      rr_d           = rr;
      write_pixel_d  = 1'b0;
      addr_d         = vram_raster_address;
      color_d        = vram_raster_color;
      offset_d       = vram_offset;
      swap_done_d    = 1'b0;

      case (state)
         IDLE: begin
            if (swap_pending) begin
               state_d = SWAP;
            end else if (grant_c != 2'b00) begin
               state_d       = WRITE;
               cnt_d         = CNT_W'(WRITE_CYCLES - 1);
               write_pixel_d = 1'b1;
               // Pointer moves to the requester that was not just served.
               rr_d          = grant_c[0];
               addr_d        = grant_c[0] ? rast_addr  : clr_addr;
               color_d       = grant_c[0] ? rast_color : clr_color;
            end
         end
         WRITE: begin
            if (cnt == '0) begin
               state_d = swap_pending ? SWAP : IDLE;
            end else begin
               cnt_d         = cnt - CNT_W'(1);
               write_pixel_d = 1'b1;
            end
         end
         SWAP: begin
            state_d        = IDLE;
            offset_d       = ~vram_offset;
            swap_done_d    = 1'b1;
            // A request landing in the SWAP cycle queues a second swap.
            swap_pending_d = swap_req;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE) || swap_pending_d;
   end

   // State and registered outputs.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state               <= IDLE;
         cnt                 <= '0;
         swap_pending        <= 1'b0;
         rr                  <= 1'b0;
         vram_write_pixel    <= 1'b0;
         vram_raster_address <= '0;
         vram_raster_color   <= '0;
         vram_offset         <= 1'b0;
         swap_done           <= 1'b0;
         busy                <= 1'b0;
      end else begin
         state               <= state_d;
         cnt                 <= cnt_d;
         swap_pending        <= swap_pending_d;
         rr                  <= rr_d;
         vram_write_pixel    <= write_pixel_d;
         vram_raster_address <= addr_d;
         vram_raster_color   <= color_d;
         vram_offset         <= offset_d;
         swap_done           <= swap_done_d;
         busy                <= busy_d;
      end
   end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: WRITE_CYCLES=2 instance for most
// scenarios, a WRITE_CYCLES=1 instance for back-to-back clear writes.
module tb_vram_write_arbiter;

   logic        wb_clk_i;
   logic        wb_rst_ni;
   logic        rast_valid, rast_ready;
   logic [17:0] rast_addr;
   logic [15:0] rast_color;
   logic        clr_valid, clr_ready;
   logic [17:0] clr_addr;
   logic [15:0] clr_color;
   logic        swap_req, swap_done, busy;
   logic        vram_write_pixel;
   logic [17:0] vram_raster_address;
   logic [15:0] vram_raster_color;
   logic        vram_offset;

   logic        u1_rast_ready, u1_clr_valid, u1_clr_ready;
   logic        u1_swap_done, u1_busy, u1_write_pixel, u1_offset;
   logic [17:0] u1_addr;
   logic [15:0] u1_color;

   int n_checks = 0;
   int n_pass   = 0;

   vram_write_arbiter #(.ADDR_W(18), .COLOR_W(16), .WRITE_CYCLES(2)) u_dut (
      .wb_clk_i            (wb_clk_i),
      .wb_rst_ni           (wb_rst_ni),
      .rast_valid          (rast_valid),
      .rast_ready          (rast_ready),
      .rast_addr           (rast_addr),
      .rast_color          (rast_color),
      .clr_valid           (clr_valid),
      .clr_ready           (clr_ready),
      .clr_addr            (clr_addr),
      .clr_color           (clr_color),
      .swap_req            (swap_req),
      .swap_done           (swap_done),
      .busy                (busy),
      .vram_write_pixel    (vram_write_pixel),
      .vram_raster_address (vram_raster_address),
      .vram_raster_color   (vram_raster_color),
      .vram_offset         (vram_offset)
   );

   vram_write_arbiter #(.ADDR_W(18), .COLOR_W(16), .WRITE_CYCLES(1)) u_dut1 (
      .wb_clk_i            (wb_clk_i),
      .wb_rst_ni           (wb_rst_ni),
      .rast_valid          (1'b0),
      .rast_ready          (u1_rast_ready),
      .rast_addr           (18'h0),
      .rast_color          (16'h0),
      .clr_valid           (u1_clr_valid),
      .clr_ready           (u1_clr_ready),
      .clr_addr            (18'h00040),
      .clr_color           (16'h07E0),
      .swap_req            (1'b0),
      .swap_done           (u1_swap_done),
      .busy                (u1_busy),
      .vram_write_pixel    (u1_write_pixel),
      .vram_raster_address (u1_addr),
      .vram_raster_color   (u1_color),
      .vram_offset         (u1_offset)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic do_reset;
      wb_rst_ni = 1'b0;
      tick();
      wb_rst_ni = 1'b1;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int waitc;
      logic gr;
      logic [17:0] exp_a;
      logic [15:0] exp_c;

      wb_rst_ni    = 1'b0;
      rast_valid   = 1'b0;
      rast_addr    = '0;
      rast_color   = '0;
      clr_valid    = 1'b0;
      clr_addr     = '0;
      clr_color    = '0;
      swap_req     = 1'b0;
      u1_clr_valid = 1'b0;

      // Reset state
      #2;
      check("rst_wp",     32'(vram_write_pixel), 32'd0);
      check("rst_offset", 32'(vram_offset), 32'd0);
      check("rst_busy",   32'(busy), 32'd0);
      check("rst_addr",   32'(vram_raster_address), 32'd0);
      tick();
      wb_rst_ni = 1'b1;
      tick();

      // Raster only, WRITE_CYCLES=2
      rast_valid = 1'b1; rast_addr = 18'h00010; rast_color = 16'hF800;
      #1;
      check("t1_rready_c1", 32'(rast_ready), 32'd1);
      check("t1_cready_c1", 32'(clr_ready), 32'd0);
      tick();
      rast_addr = 18'h00011; rast_color = 16'h0001;
      #1;
      check("t1_wp_c2",     32'(vram_write_pixel), 32'd1);
      check("t1_addr_c2",   32'(vram_raster_address), 32'h10);
      check("t1_color_c2",  32'(vram_raster_color), 32'hF800);
      check("t1_rready_c2", 32'(rast_ready), 32'd0);
      check("t1_busy_c2",   32'(busy), 32'd1);
      tick();
      check("t1_wp_c3",     32'(vram_write_pixel), 32'd1);
      check("t1_addr_c3",   32'(vram_raster_address), 32'h10);
      check("t1_rready_c3", 32'(rast_ready), 32'd0);
      tick();
      check("t1_wp_c4",     32'(vram_write_pixel), 32'd0);
      check("t1_rready_c4", 32'(rast_ready), 32'd1);
      check("t1_addr_c4",   32'(vram_raster_address), 32'h10);
      rast_valid = 1'b0;
      #1;
      tick();

      // Both valid: strict alternation starting with raster
      do_reset();
      rast_valid = 1'b1; rast_addr = 18'h00100; rast_color = 16'h1000;
      clr_valid  = 1'b1; clr_addr  = 18'h00200; clr_color  = 16'h2000;
      #1;
      for (int g = 0; g < 6; g++) begin
         waitc = 0;
         while (!(rast_ready || clr_ready) && waitc < 8) begin
            tick();
            waitc++;
         end
         check("t2_excl", 32'(rast_ready && clr_ready), 32'd0);
         check("t2_rsel", 32'(rast_ready), 32'((g % 2) == 0));
         if (g > 0) check("t2_gap", 32'(waitc), 32'd2);
         gr = rast_ready;
         exp_a = ((g % 2) == 0) ? 18'(18'h00100 + g / 2) : 18'(18'h00200 + g / 2);
         exp_c = ((g % 2) == 0) ? 16'(16'h1000 + g / 2)  : 16'(16'h2000 + g / 2);
         tick();
         check("t2_wp",    32'(vram_write_pixel), 32'd1);
         check("t2_addr",  32'(vram_raster_address), 32'(exp_a));
         check("t2_color", 32'(vram_raster_color), 32'(exp_c));
         if (gr) begin
            rast_addr  = 18'(rast_addr + 1);
            rast_color = 16'(rast_color + 1);
         end else begin
            clr_addr  = 18'(clr_addr + 1);
            clr_color = 16'(clr_color + 1);
         end
      end
      rast_valid = 1'b0; clr_valid = 1'b0;
      tick(); tick(); tick();

      // Swap requested during the first WRITE cycle
      rast_valid = 1'b1; rast_addr = 18'h00033; rast_color = 16'h0033;
      #1;
      check("t3_rready", 32'(rast_ready), 32'd1);
      tick();
      rast_valid = 1'b0; swap_req = 1'b1; clr_valid = 1'b1; clr_addr = 18'h00077;
      #1;
      check("t3_cready_w1", 32'(clr_ready), 32'd0);
      tick();
      swap_req = 1'b0;
      check("t3_wp_w2",     32'(vram_write_pixel), 32'd1);
      check("t3_addr_w2",   32'(vram_raster_address), 32'h33);
      check("t3_off_w2",    32'(vram_offset), 32'd0);
      check("t3_cready_w2", 32'(clr_ready), 32'd0);
      tick();
      check("t3_wp_swap",     32'(vram_write_pixel), 32'd0);
      check("t3_off_swap",    32'(vram_offset), 32'd0);
      check("t3_done_swap",   32'(swap_done), 32'd0);
      check("t3_cready_swap", 32'(clr_ready), 32'd0);
      check("t3_busy_swap",   32'(busy), 32'd1);
      tick();
      check("t3_off_after",    32'(vram_offset), 32'd1);
      check("t3_done_after",   32'(swap_done), 32'd1);
      check("t3_cready_after", 32'(clr_ready), 32'd1);
      clr_valid = 1'b0;
      #1;
      tick();
      check("t3_done_clr", 32'(swap_done), 32'd0);
      check("t3_busy_end", 32'(busy), 32'd0);

      // Two back-to-back swap requests collapse into one toggle
      swap_req = 1'b1;
      tick();
      check("t4_busy_pend", 32'(busy), 32'd1);
      tick();
      swap_req = 1'b0;
      check("t4_off_swap", 32'(vram_offset), 32'd1);
      tick();
      check("t4_off_1", 32'(vram_offset), 32'd0);
      check("t4_done_1", 32'(swap_done), 32'd1);
      tick();
      check("t4_off_hold", 32'(vram_offset), 32'd0);
      check("t4_done_0", 32'(swap_done), 32'd0);
      check("t4_busy_0", 32'(busy), 32'd0);
      // Request during the SWAP cycle queues a second toggle
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      tick();
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      check("t4_off_a",  32'(vram_offset), 32'd1);
      check("t4_done_a", 32'(swap_done), 32'd1);
      check("t4_busy_a", 32'(busy), 32'd1);
      tick();
      check("t4_off_b",  32'(vram_offset), 32'd1);
      check("t4_done_b", 32'(swap_done), 32'd0);
      tick();
      check("t4_off_c",  32'(vram_offset), 32'd0);
      check("t4_done_c", 32'(swap_done), 32'd1);
      tick();

      // Reset during the second strobe cycle
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      tick(); tick();
      check("t5_off_pre", 32'(vram_offset), 32'd1);
      rast_valid = 1'b1; rast_addr = 18'h00055; rast_color = 16'h0055;
      #1;
      tick();
      rast_valid = 1'b0;
      tick();
      check("t5_wp_pre", 32'(vram_write_pixel), 32'd1);
      wb_rst_ni = 1'b0; rast_valid = 1'b1; clr_valid = 1'b1; rast_addr = 18'h00066;
      #1;
      check("t5_wp_rst",     32'(vram_write_pixel), 32'd0);
      check("t5_off_rst",    32'(vram_offset), 32'd0);
      check("t5_rready_rst", 32'(rast_ready), 32'd0);
      check("t5_cready_rst", 32'(clr_ready), 32'd0);
      check("t5_busy_rst",   32'(busy), 32'd0);
      tick();
      wb_rst_ni = 1'b1;
      #1;
      check("t5_wp_rel",     32'(vram_write_pixel), 32'd0);
      check("t5_rready_rel", 32'(rast_ready), 32'd1);
      check("t5_cready_rel", 32'(clr_ready), 32'd0);
      tick();
      check("t5_addr", 32'(vram_raster_address), 32'h66);
      rast_valid = 1'b0; clr_valid = 1'b0;
      tick(); tick(); tick();

      // WRITE_CYCLES=1, clear only, four pixels
      u1_clr_valid = 1'b1;
      #1;
      check("t6_cready_0", 32'(u1_clr_ready), 32'd1);
      tick();
      for (int i = 0; i < 8; i++) begin
         check("t6_wp",   32'(u1_write_pixel), 32'((i % 2) == 0 && i < 7));
         check("t6_busy", 32'(u1_busy), 32'((i % 2) == 0 && i < 7));
         if (i == 1 || i == 3 || i == 5) check("t6_cready", 32'(u1_clr_ready), 32'd1);
         if (i == 6) u1_clr_valid = 1'b0;
         tick();
      end
      check("t6_addr", 32'(u1_addr), 32'h40);
      check("t6_color", 32'(u1_color), 32'h07E0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
